// File: rtl/eth10_pkg.sv
// Shared types and constants for the 10BASE-T receive front end.
package eth10_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } rx_state_e;

  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [7:0] ETH_PRE = 8'h55;

  // Below this many cycles since the last mid-bit edge, a transition is a glitch.
  function automatic int glitch_thr(input int spb);
    return spb / 4;
  endfunction

  // At or above this many cycles, a transition is accepted as a mid-bit edge.
  function automatic int mid_thr(input int spb);
    return (3 * spb) / 4;
  endfunction

  // Quiet time that ends the carrier.
  function automatic int loss_thr(input int spb);
    return 2 * spb;
  endfunction

endpackage

// File: rtl/eth10_manchester_dec.sv
// Manchester line decoder: input sync, level extraction, bit timing and
// transition classification. NLP_DET_EN adds the raw positive-level output.
module eth10_manchester_dec
  import eth10_pkg::*;
#(
  parameter int SPB = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxp,
  input  logic rxn,
  input  logic idle,
  output logic bit_vld,
  output logic bit_val,
  output logic glitch,
  output logic carrier_lost
`ifdef NLP_DET_EN
  ,
  output logic line_pos
`endif
);

  localparam int CW = $clog2(2 * SPB + 1);
  localparam logic [CW-1:0] C_GLITCH = CW'(glitch_thr(SPB));
  localparam logic [CW-1:0] C_MID    = CW'(mid_thr(SPB));
  localparam logic [CW-1:0] C_LOSS   = CW'(loss_thr(SPB));
  localparam logic [CW-1:0] C_LAST   = CW'(loss_thr(SPB) - 1);

  logic [1:0]    p_sync_q, n_sync_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_s, n_s, trans;

  always_comb begin
    p_s   = p_sync_q[1];
    n_s   = n_sync_q[1];
    lvl_d = lvl_q;
    if (p_s && !n_s) begin
      lvl_d = 1'b1;
    end else if (!p_s && n_s) begin
      lvl_d = 1'b0;
    end
    trans   = (lvl_d != lvl_q);
    // In IDLE there is no bit timing yet, so any edge seeds it.
    bit_vld = trans && (idle || (cnt_q >= C_MID));
    bit_val = lvl_d;
    glitch  = trans && !idle && (cnt_q < C_GLITCH);
    cnt_d   = cnt_q;
    if (bit_vld) begin
      cnt_d = '0;
    end else if (cnt_q != C_LOSS) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Single-cycle event on the cycle cnt arrives at the loss threshold.
    carrier_lost = !bit_vld && (cnt_q == C_LAST);
  end

`ifdef NLP_DET_EN
  assign line_pos = p_s && !n_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sync_q <= '0;
      n_sync_q <= '0;
      lvl_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      p_sync_q <= {p_sync_q[0], rxp};
      n_sync_q <= {n_sync_q[0], rxn};
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/eth10base_t_rx.sv
// 10BASE-T receive front end: preamble/SFD hunt and LSB-first byte assembly.
// Define NLP_DET_EN to enable normal-link-pulse detection and the link timer.
module eth10base_t_rx
  import eth10_pkg::*;
#(
  parameter int SPB      = 8,
  parameter int LINK_MAX = 1920000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rxp,
  input  logic       Rxn,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       RxSof,
  output logic       RxEof,
  output logic       RxErr,
  output logic       Crs,
  output logic       LinkOk
);

  if ((SPB < 8) || (SPB % 2 != 0) || (LINK_MAX < 1)) begin : g_bad_param
    $error("eth10base_t_rx: SPB must be even and >= 8, LINK_MAX >= 1");
  end

  rx_state_e  state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d, shift_in;
  logic [3:0] hist_q, hist_d, hist_in;
  logic       first_q, first_d, valid_q, valid_d, sof_q, sof_d;
  logic       eof_q, eof_d, err_q, err_d, crs_q, crs_d;
  logic       bit_vld, bit_val, glitch, carrier_lost, link_ok;
`ifdef NLP_DET_EN
  logic       line_pos;
`endif

  eth10_manchester_dec #(.SPB(SPB)) u_dec (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxp          (Rxp),
    .rxn          (Rxn),
    .idle         (state_q == IDLE),
`ifdef NLP_DET_EN
    .line_pos     (line_pos),
`endif
    .bit_vld      (bit_vld),
    .bit_val      (bit_val),
    .glitch       (glitch),
    .carrier_lost (carrier_lost)
  );

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    hist_d   = hist_q;
    first_d  = first_q;
    crs_d    = crs_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    shift_in = {bit_val, shift_q[7:1]};
    hist_in  = {bit_val, hist_q[3:1]};
    unique case (state_q)
      IDLE: begin
        if (bit_vld && link_ok) begin
          crs_d   = 1'b1;
          hist_d  = {bit_val, 3'b000};
          state_d = HUNT;
        end
      end
      HUNT: begin
        if (carrier_lost) begin
          crs_d   = 1'b0;
          state_d = IDLE;
        end else if (bit_vld) begin
          hist_d = hist_in;
          // History fills MSB-first in time, so it lines up with the SFD's top nibble.
          if (hist_in == ETH_SFD[7:4]) begin
            bitcnt_d = '0;
            first_d  = 1'b1;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (glitch) begin
          eof_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DRAIN;
        end else if (carrier_lost) begin
          eof_d   = 1'b1;
          err_d   = (bitcnt_q != 3'd0);
          crs_d   = 1'b0;
          state_d = IDLE;
        end else if (bit_vld) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            data_d  = shift_in;
            valid_d = 1'b1;
            sof_d   = first_q;
            first_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (carrier_lost) begin
          crs_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      hist_q   <= '0;
      first_q  <= 1'b0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      crs_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      hist_q   <= hist_d;
      first_q  <= first_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      crs_q    <= crs_d;
    end
  end

`ifdef NLP_DET_EN
  localparam int PW_W = $clog2(2 * SPB + 2);
  localparam int LT_W = $clog2(LINK_MAX + 1);

  logic [PW_W-1:0] pw_q, pw_d;
  logic [LT_W-1:0] ltmr_q, ltmr_d;
  logic            link_q, link_d, nlp_seen;

  always_comb begin
    pw_d     = pw_q;
    nlp_seen = 1'b0;
    ltmr_d   = ltmr_q;
    link_d   = link_q;
    if (line_pos) begin
      if (pw_q != PW_W'(2 * SPB + 1)) begin
        pw_d = pw_q + 1'b1;
      end
    end else begin
      pw_d     = '0;
      nlp_seen = (state_q == IDLE) && (pw_q >= PW_W'(SPB / 2)) && (pw_q <= PW_W'(2 * SPB));
    end
    // Timer parks at its last value once the link is declared down.
    if (nlp_seen || eof_d) begin
      ltmr_d = '0;
      link_d = 1'b1;
    end else if (ltmr_q == LT_W'(LINK_MAX - 1)) begin
      link_d = 1'b0;
    end else begin
      ltmr_d = ltmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_q   <= '0;
      ltmr_q <= '0;
      link_q <= 1'b0;
    end else begin
      pw_q   <= pw_d;
      ltmr_q <= ltmr_d;
      link_q <= link_d;
    end
  end

  assign link_ok = link_q;
`else
  assign link_ok = 1'b1;
`endif

  assign RxData  = data_q;
  assign RxValid = valid_q;
  assign RxSof   = sof_q;
  assign RxEof   = eof_q;
  assign RxErr   = err_q;
  assign Crs     = crs_q;
  assign LinkOk  = link_ok;

endmodule

// File: tb/tb_eth10base_t_rx.sv
// Bench for eth10base_t_rx: Manchester line driver, event scoreboard and a
// frame-level reference model (bytes, partial-bit errors, strobe timing).
module tb_eth10base_t_rx;
  import eth10_pkg::*;

  localparam int SPB = 8;

  logic       clk, rst_n, Rxp, Rxn;
  logic [7:0] RxData;
  logic       RxValid, RxSof, RxEof, RxErr, Crs, LinkOk;

  eth10base_t_rx #(.SPB(SPB), .LINK_MAX(1920000)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Rxp     (Rxp),
    .Rxn     (Rxn),
    .RxData  (RxData),
    .RxValid (RxValid),
    .RxSof   (RxSof),
    .RxEof   (RxEof),
    .RxErr   (RxErr),
    .Crs     (Crs),
    .LinkOk  (LinkOk)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_rx  = 0;
  int last_mid;
  logic [40:0] exp_q[$];  // {sof, data, cycle}
  logic [33:0] eof_q[$];  // {crs, err, cycle}
  logic        pend_en;
  logic [8:0]  pend_val;  // {sof, data}
  logic [7:0]  pay[4];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h expected no event", name, act);
  endfunction

  logic [40:0] mon_e;
  logic [33:0] mon_f;
  always @(negedge clk) begin
    if (rst_n) begin
      if (RxValid) begin
        n_rx++;
        if (exp_q.size() == 0) flag("unexpected_byte", 64'(RxData));
        else begin
          mon_e = exp_q.pop_front();
          check("byte_data", 64'(RxData), 64'(mon_e[39:32]));
          check("byte_sof", 64'(RxSof), 64'(mon_e[40]));
          check("byte_time", 64'(cyc), 64'(mon_e[31:0]));
        end
      end
      if (RxEof) begin
        if (RxValid) flag("eof_with_valid", 64'(RxData));
        if (eof_q.size() == 0) flag("unexpected_eof", 64'(RxErr));
        else begin
          mon_f = eof_q.pop_front();
          check("eof_err", 64'(RxErr), 64'(mon_f[32]));
          check("eof_crs", 64'(Crs), 64'(mon_f[33]));
          check("eof_time", 64'(cyc), 64'(mon_f[31:0]));
        end
      end
      if (RxErr && !RxEof) flag("err_without_eof", 64'(RxErr));
      if (RxSof && !RxValid) flag("sof_without_valid", 64'(RxSof));
    end
  end

  // ---------------- driver tasks ----------------
  // One Manchester bit: first half ~b, second half b (mid-bit edge carries b).
  // With glt set, the line flips for one cycle right after the mid-bit edge.
  task automatic send_bit(input logic b, input logic glt);
    for (int i = 0; i < SPB; i++) begin
      @(negedge clk);
      Rxp = (i < SPB / 2) ? ~b : b;
      if (i == SPB / 2) begin
        last_mid = cyc;
        if (pend_en) begin
          exp_q.push_back({pend_val, 32'(cyc + 3)});
          pend_en = 1'b0;
        end
      end
      if (glt && (i == SPB / 2 + 1)) begin
        Rxp = ~b;
        eof_q.push_back({1'b1, 1'b1, 32'(cyc + 3)});
      end
      Rxn = ~Rxp;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic track, input logic sof);
    for (int i = 0; i < 8; i++) begin
      if (track && (i == 7)) begin
        pend_val = {sof, v};
        pend_en  = 1'b1;
      end
      send_bit(v[i], 1'b0);
    end
  endtask

  // TP_IDL positive level for 2.5 bit times, then both legs idle.
  task automatic send_tail();
    repeat (2 * SPB + SPB / 2) begin
      @(negedge clk);
      Rxp = 1'b1;
      Rxn = 1'b0;
    end
    repeat (4 * SPB) begin
      @(negedge clk);
      Rxp = 1'b0;
      Rxn = 1'b0;
    end
  endtask

  task automatic send_frame(input int n_pre, input int n_pay, input int n_extra,
                            input logic [7:0] extra, input logic glt, input logic exp_err);
    n_rx = 0;
    repeat (n_pre) send_byte(ETH_PRE, 1'b0, 1'b0);
    send_byte(ETH_SFD, 1'b0, 1'b0);
    check("crs_in_frame", 64'(Crs), 64'd1);
    for (int i = 0; i < n_pay; i++) send_byte(pay[i], 1'b1, i == 0);
    for (int i = 0; i < n_extra; i++) send_bit(extra[i], 1'b0);
    if (glt) begin
      send_bit(1'b1, 1'b1);
      repeat (3) send_bit(1'b0, 1'b0);
    end else begin
      // Carrier loss lands 2*SPB cycles after the strobe slot of the last bit.
      eof_q.push_back({1'b0, exp_err, 32'(last_mid + 3 + 2 * SPB)});
    end
    send_tail();
  endtask

  task automatic end_checks(input int exp_bytes);
    check("byte_count", 64'(n_rx), 64'(exp_bytes));
    check("bytes_pending", 64'(exp_q.size()), 64'd0);
    check("eofs_pending", 64'(eof_q.size()), 64'd0);
    check("crs_after_frame", 64'(Crs), 64'd0);
    check("link_ok", 64'(LinkOk), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("reset_outputs", 64'({RxData, RxValid, RxSof, RxEof, RxErr, Crs, LinkOk}), 64'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         n_pay;
    logic [7:0] b0, b1, b2;
    int         n_extra;
    logic [7:0] extra;
    logic       glt;
    int         exp_bytes;
    logic       exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         np, ne;
    logic [7:0] part;

    vecs[0] = '{2, 8'h01, 8'hAB, 8'h00, 0, 8'h00, 1'b0, 2, 1'b0};
    vecs[1] = '{1, 8'h3C, 8'h00, 8'h00, 4, 8'h0A, 1'b0, 1, 1'b1};
    vecs[2] = '{1, 8'h01, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1, 1'b1};
    vecs[3] = '{3, 8'hFF, 8'h00, 8'hD5, 0, 8'h00, 1'b0, 3, 1'b0};
    vecs[4] = '{1, 8'hA5, 8'h00, 8'h00, 7, 8'h5B, 1'b0, 1, 1'b1};

    pend_en  = 1'b0;
    pend_val = '0;
    rst_n    = 1'b0;
    Rxp      = 1'b0;
    Rxn      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (4 * SPB) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      pay[0] = vecs[v].b0;
      pay[1] = vecs[v].b1;
      pay[2] = vecs[v].b2;
      send_frame(7, vecs[v].n_pay, vecs[v].n_extra, vecs[v].extra, vecs[v].glt, vecs[v].exp_err);
      end_checks(vecs[v].exp_bytes);
    end

    // Alternating bits with no SFD: carrier only.
    n_rx = 0;
    for (int i = 0; i < 64; i++) begin
      send_bit(logic'(i % 2 == 0), 1'b0);
      if (i == 32) check("crs_no_sfd", 64'(Crs), 64'd1);
    end
    send_tail();
    end_checks(0);

    // Reset in the middle of a byte, then a clean frame.
    part = 8'h77;
    repeat (3) send_byte(ETH_PRE, 1'b0, 1'b0);
    send_byte(ETH_SFD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    Rxp   = 1'b0;
    Rxn   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    rst_n = 1'b1;
    repeat (4 * SPB) @(negedge clk);
    pay[0] = 8'h5A;
    send_frame(7, 1, 0, 8'h00, 1'b0, 1'b0);
    end_checks(1);

    // Randomized frames against the frame-level model.
    for (int r = 0; r < 6; r++) begin
      np = $urandom_range(1, 3);
      ne = $urandom_range(0, 7);
      for (int i = 0; i < np; i++) pay[i] = 8'($urandom);
      send_frame($urandom_range(2, 7), np, ne, 8'($urandom), 1'b0, ne != 0);
      end_checks(np);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
